// File: rtl/jt49_pkg.sv
// Shared definitions for the JT49 command sequencer: word layout, FSM encoding
// and a helper that assembles a queued command word.
package jt49_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int WORD_W   = 1 + ADDR_W + DATA_W;
  localparam int WAIT_BIT = WORD_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } seq_state_e;

  // The wait flag is the MSB so the packed word matches {cmd_wait, cmd_addr, cmd_data}.
  typedef struct packed {
    logic              is_wait;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_word_t;

  function automatic cmd_word_t pack_cmd(input logic              is_wait,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
    cmd_word_t w;
    w.is_wait = is_wait;
    w.addr    = addr;
    w.data    = data;
    return w;
  endfunction

endpackage

// File: rtl/jt49_seq_if.sv
// Command, host and PSG register bus signals of the sequencer. The slave
// modport is the sequencer; the master modport is whatever feeds it.
interface jt49_seq_if #(
  parameter int QW = 3
);
  import jt49_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wait;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              host_req;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_gnt;

  logic              psg_cs_n;
  logic              psg_wr_n;
  logic [ADDR_W-1:0] psg_addr;
  logic [DATA_W-1:0] psg_din;

  logic [QW:0]       level;
  logic              idle;

  modport master (
    output cmd_valid, cmd_wait, cmd_addr, cmd_data,
    output host_req, host_wr, host_addr, host_din,
    input  cmd_ready, host_gnt,
    input  psg_cs_n, psg_wr_n, psg_addr, psg_din,
    input  level, idle
  );

  modport slave (
    input  cmd_valid, cmd_wait, cmd_addr, cmd_data,
    input  host_req, host_wr, host_addr, host_din,
    output cmd_ready, host_gnt,
    output psg_cs_n, psg_wr_n, psg_addr, psg_din,
    output level, idle
  );

endinterface

// File: rtl/jt49_seq_fifo.sv
// Command FIFO of 2**QW words. A pushed word is visible the cycle after the
// push; flush empties it synchronously.
module jt49_seq_fifo
  import jt49_pkg::*;
#(
  parameter int QW = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  input  logic      push_i,
  input  cmd_word_t din_i,
  input  logic      pop_i,
  output cmd_word_t dout_o,
  output logic      full_o,
  output logic      empty_o,
  output logic [QW:0] level_o
);

  localparam int DEPTH = 2 ** QW;

  cmd_word_t     mem_q [DEPTH];
  logic [QW-1:0] wr_ptr_q;
  logic [QW-1:0] rd_ptr_q;
  logic [QW:0]   level_q;

  // NOTE: the storage array is deliberately not reset; level and pointers alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == (QW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/jt49_seq.sv
// PSG register-write sequencer: arbitrates a queued command stream against
// direct host accesses and drives one-cycle strobes on the PSG register bus.
module jt49_seq
  import jt49_pkg::*;
#(
  parameter int QW     = 3,
  parameter int STARVE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       flush,
  jt49_seq_if.slave  bus
);

  localparam int              SW         = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]     host_wins_q, host_wins_d;
  logic              psg_cs_n_q, psg_cs_n_d;
  logic              psg_wr_n_q, psg_wr_n_d;
  logic [ADDR_W-1:0] psg_addr_q, psg_addr_d;
  logic [DATA_W-1:0] psg_din_q, psg_din_d;

  cmd_word_t   head;
  logic        fifo_full, fifo_empty;
  logic [QW:0] fifo_level;
  logic        cmd_ready, push;
  logic        arb_slot, head_ok, starved, host_win, queue_win;

  assign cmd_ready = !fifo_full && !flush;
  assign push      = bus.cmd_valid && cmd_ready;

  jt49_seq_fifo #(.QW(QW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (pack_cmd(bus.cmd_wait, bus.cmd_addr, bus.cmd_data)),
    .pop_i   (queue_win),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // A flushing queue never competes, so nothing is popped out of a dying FIFO.
  assign arb_slot  = (state_q == ST_IDLE) && cen;
  assign head_ok   = !fifo_empty && !flush;
  assign starved   = head_ok && (host_wins_q == STARVE_MAX);
  assign host_win  = arb_slot && bus.host_req && !starved;
  assign queue_win = arb_slot && head_ok && !host_win;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    psg_cs_n_d  = 1'b1;
    psg_wr_n_d  = 1'b1;
    psg_addr_d  = psg_addr_q;
    psg_din_d   = psg_din_q;
    host_wins_d = host_wins_q;

    case (state_q)
      ST_IDLE: begin
        if (host_win) begin
          psg_cs_n_d = 1'b0;
          psg_wr_n_d = !bus.host_wr;
          psg_addr_d = bus.host_addr;
          psg_din_d  = bus.host_din;
          state_d    = ST_STROBE;
        end else if (queue_win) begin
          if (head.is_wait) begin
            wait_cnt_d = head.data;
            state_d    = ST_WAIT;
          end else begin
            psg_cs_n_d = 1'b0;
            psg_wr_n_d = 1'b0;
            psg_addr_d = head.addr;
            psg_din_d  = head.data;
            state_d    = ST_STROBE;
          end
        end
      end
      ST_STROBE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (flush) begin
          wait_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (cen) begin
          if (wait_cnt_q == '0) state_d = ST_IDLE;
          else                  wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host streak only matters while the queue has something to offer.
    if (flush || fifo_empty)                    host_wins_d = '0;
    else if (host_win && host_wins_q != STARVE_MAX) host_wins_d = host_wins_q + 1'b1;
    else if (queue_win)                         host_wins_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      host_wins_q <= '0;
      psg_cs_n_q  <= 1'b1;
      psg_wr_n_q  <= 1'b1;
      psg_addr_q  <= '0;
      psg_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      host_wins_q <= host_wins_d;
      psg_cs_n_q  <= psg_cs_n_d;
      psg_wr_n_q  <= psg_wr_n_d;
      psg_addr_q  <= psg_addr_d;
      psg_din_q   <= psg_din_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.host_gnt  = host_win;
  assign bus.psg_cs_n  = psg_cs_n_q;
  assign bus.psg_wr_n  = psg_wr_n_q;
  assign bus.psg_addr  = psg_addr_q;
  assign bus.psg_din   = psg_din_q;
  assign bus.level     = fifo_level;
  assign bus.idle      = fifo_empty && (state_q == ST_IDLE) && psg_cs_n_q;

endmodule

// File: tb/tb_jt49_seq.sv
// Bench for jt49_seq: directed scenarios plus random traffic, each cycle
// compared against a queue-based transaction model of the sequencer.
module tb_jt49_seq;
  import jt49_pkg::*;

  localparam int QW     = 3;
  localparam int STARVE = 4;
  localparam int DEPTH  = 2 ** QW;

  typedef struct {
    logic              wr_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    int                tick;
  } strobe_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic cen   = 1'b0;
  logic flush = 1'b0;

  jt49_seq_if #(.QW(QW)) bus ();

  jt49_seq #(.QW(QW), .STARVE(STARVE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending commands, remaining wait ticks (-1 = none),
  // host streak, and the PSG bus values expected in the current cycle.
  logic [WORD_W-1:0] m_q[$];
  int                m_wait;
  int                m_hwins;
  logic              m_cs_n, m_wr_n;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;

  strobe_t obs[$];
  int      wait_pops[$];
  int      cen_ticks = 0;
  int      cyc_n     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wait  = -1;
    m_hwins = 0;
    m_cs_n  = 1'b1;
    m_wr_n  = 1'b1;
    m_addr  = '0;
    m_din   = '0;
  endtask

  // One clock: compare at negedge with inputs settled, advance the model,
  // then return just after the next posedge for the caller to drive inputs.
  task automatic step();
    bit                free, q_ok, hwin, qwin, push, ready;
    logic [WORD_W-1:0] head;
    @(negedge clk);
    free  = m_cs_n && (m_wait < 0);
    q_ok  = (m_q.size() > 0) && !flush;
    hwin  = free && cen && bus.host_req && !(q_ok && m_hwins >= STARVE);
    qwin  = free && cen && q_ok && !hwin;
    ready = (m_q.size() < DEPTH) && !flush;
    push  = bus.cmd_valid && ready;

    check("cmd_ready", bus.cmd_ready, ready);
    check("level",     bus.level, m_q.size());
    check("host_gnt",  bus.host_gnt, hwin);
    check("psg_cs_n",  bus.psg_cs_n, m_cs_n);
    check("psg_wr_n",  bus.psg_wr_n, m_wr_n);
    check("psg_addr",  bus.psg_addr, m_addr);
    check("psg_din",   bus.psg_din, m_din);
    check("idle",      bus.idle, (m_q.size() == 0) && (m_wait < 0) && m_cs_n);
    if (bus.psg_cs_n === 1'b0)
      obs.push_back('{bus.psg_wr_n, bus.psg_addr, bus.psg_din, cen_ticks - 1});

    if (flush || m_q.size() == 0) m_hwins = 0;
    else if (hwin)                m_hwins = (m_hwins < STARVE) ? m_hwins + 1 : STARVE;
    else if (qwin)                m_hwins = 0;

    if (flush)                       m_wait = -1;
    else if (m_wait >= 0 && cen)     m_wait = (m_wait == 0) ? -1 : m_wait - 1;

    m_cs_n = 1'b1;
    m_wr_n = 1'b1;
    if (hwin) begin
      m_cs_n = 1'b0;
      m_wr_n = !bus.host_wr;
      m_addr = bus.host_addr;
      m_din  = bus.host_din;
    end
    if (qwin) begin
      head = m_q.pop_front();
      if (head[WAIT_BIT]) begin
        m_wait = int'(head[DATA_W-1:0]);
        wait_pops.push_back(cen_ticks);
      end else begin
        m_cs_n = 1'b0;
        m_wr_n = 1'b0;
        m_addr = head[DATA_W +: ADDR_W];
        m_din  = head[DATA_W-1:0];
      end
    end
    if (flush)     m_q.delete();
    else if (push) m_q.push_back({bus.cmd_wait, bus.cmd_addr, bus.cmd_data});

    if (cen) cen_ticks++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      cen = ((cyc_n % period) == 0);
      step();
      cyc_n++;
    end
    cen = 1'b0;
  endtask

  task automatic push_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cen           = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wait  = w;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    bus.cmd_valid = 1'b0;
    bus.cmd_wait  = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.host_req  = 1'b0;
    bus.host_wr   = 1'b0;
    bus.host_addr = '0;
    bus.host_din  = '0;
    model_reset();

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_cs_n",  bus.psg_cs_n, 1'b1);
    check("rst_wr_n",  bus.psg_wr_n, 1'b1);
    check("rst_addr",  bus.psg_addr, 0);
    check("rst_din",   bus.psg_din, 0);
    check("rst_level", bus.level, 0);
    check("rst_gnt",   bus.host_gnt, 0);
    check("rst_idle",  bus.idle, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // Two queued writes, cen every 4 clocks
    push_cmd(1'b0, 4'd7, 8'h38);
    push_cmd(1'b0, 4'd8, 8'h0F);
    check("wr2_level_full", bus.level, 2);
    obs.delete();
    run(16, 4);
    check("wr2_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      check("wr2_a0", {obs[0].wr_n, obs[0].addr, obs[0].din}, {1'b0, 4'd7, 8'h38});
      check("wr2_a1", {obs[1].wr_n, obs[1].addr, obs[1].din}, {1'b0, 4'd8, 8'h0F});
      check("wr2_consecutive", obs[1].tick - obs[0].tick, 1);
    end
    check("wr2_level_empty", bus.level, 0);

    // Wait of 3 then a write: four cen ticks spent waiting
    obs.delete();
    wait_pops.delete();
    push_cmd(1'b1, 4'd0, 8'd3);
    push_cmd(1'b0, 4'd0, 8'h55);
    run(40, 4);
    check("wait_strobes", obs.size(), 1);
    check("wait_pops", wait_pops.size(), 1);
    if (obs.size() >= 1 && wait_pops.size() >= 1) begin
      check("wait_data", {obs[0].addr, obs[0].din}, {4'd0, 8'h55});
      check("wait_ticks", obs[0].tick - wait_pops[0] - 1, 4);
    end

    // Starvation guard with host_req held and six queued writes
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 4'(i + 1), 8'(8'h10 + i));
    obs.delete();
    bus.host_req  = 1'b1;
    bus.host_wr   = 1'b0;
    bus.host_addr = 4'd5;
    bus.host_din  = 8'hA5;
    run(48, 4);
    bus.host_req = 1'b0;
    check("starve_count", obs.size() >= 10, 1'b1);
    pat = '0;
    if (obs.size() >= 10) for (int i = 0; i < 10; i++) pat[i] = obs[i].wr_n;
    check("starve_pattern", pat, 10'b0111101111);
    if (obs.size() >= 5) begin
      check("host_read_wr_n", obs[0].wr_n, 1'b1);
      check("host_addr_latch", {obs[0].addr, obs[0].din}, {4'd5, 8'hA5});
      check("starve_q_first", {obs[4].addr, obs[4].din}, {4'd1, 8'h10});
    end
    run(40, 4);
    check("starve_drained", bus.level, 0);

    // Fill to full, refuse a ninth, one pop reopens
    for (int i = 0; i < DEPTH; i++) push_cmd(1'b0, 4'(i), 8'(i));
    check("full_ready", bus.cmd_ready, 1'b0);
    check("full_level", bus.level, DEPTH);
    push_cmd(1'b0, 4'hF, 8'hFF);
    check("full_ninth", bus.level, DEPTH);
    cen = 1'b1;
    step();
    cen = 1'b0;
    check("full_ready_after_pop", bus.cmd_ready, 1'b1);
    check("full_level_after_pop", bus.level, DEPTH - 1);
    run(40, 2);

    // Flush during a long wait with three writes behind it
    push_cmd(1'b1, 4'd0, 8'd200);
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 4'(i + 2), 8'(8'h20 + i));
    run(4, 4);
    check("flush_pre_level", bus.level, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_level", bus.level, 0);
    check("flush_idle", bus.idle, 1'b1);
    obs.delete();
    run(80, 4);
    check("flush_no_strobe", obs.size(), 0);

    // Reset in the middle of a strobe
    push_cmd(1'b0, 4'hA, 8'h77);
    cen = 1'b1;
    step();
    cen = 1'b0;
    check("mid_strobe_cs_n", bus.psg_cs_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n", bus.psg_cs_n, 1'b1);
    check("rst_mid_wr_n", bus.psg_wr_n, 1'b1);
    check("rst_mid_bus",  {bus.psg_addr, bus.psg_din}, 0);
    check("rst_mid_idle", bus.idle, 1'b1);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs.delete();
    run(40, 4);
    check("rst_no_reissue", obs.size(), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cen           = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 59) == 0);
      bus.cmd_valid = $urandom_range(0, 1);
      bus.cmd_wait  = ($urandom_range(0, 7) == 0);
      bus.cmd_addr  = 4'($urandom);
      bus.cmd_data  = bus.cmd_wait ? 8'($urandom_range(0, 5)) : 8'($urandom);
      bus.host_req  = ($urandom_range(0, 9) < 3);
      bus.host_wr   = $urandom_range(0, 1);
      bus.host_addr = 4'($urandom);
      bus.host_din  = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
